ksa_core: RTL and testbench

RC4 key-scheduling engine owning a 256×8 state RAM. On `start` it fills the RAM with the identity permutation (S[i] = i), then runs the RC4 key-scheduling swap loop with a 24-bit secret key. It then pulses `done`, leaving the scheduled permutation in RAM for the downstream keystream/decrypt stage or for read-back.

---
 rtl/ksa_core.sv | 191 +++++++++++++++++++
 tb/tb_ksa_core.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ksa_core.sv
// ksa_core -- RC4 key-scheduling engine with an internal 256x8 state RAM.
//
// On start the RAM is filled with the identity permutation (S[i] = i), then
// the RC4 KSA swap loop runs with a 3-byte key. A one-cycle done pulse marks
// completion; the scheduled permutation stays in RAM afterwards.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   start       in   one-cycle run request, ignored while busy
//   secret_key  in   24-bit key, k0=[23:16] k1=[15:8] k2=[7:0]
//   busy        out  high from the cycle after start acceptance until done
//   done        out  one-cycle completion pulse
//   dbg_rd      in   debug read enable         (KSA_DEBUG_PORT_EN only)
//   dbg_addr    in   debug read address        (KSA_DEBUG_PORT_EN only)
//   dbg_q       out  RAM read data, 1-cycle latency (KSA_DEBUG_PORT_EN only)
//
// Build option: define KSA_DEBUG_PORT_EN to add the dbg_* read-back port.

module ksa_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] secret_key,
    output logic        busy,
    output logic        done
`ifdef KSA_DEBUG_PORT_EN
    ,
    input  logic        dbg_rd,
    input  logic [7:0]  dbg_addr,
    output logic [7:0]  dbg_q
`endif
);

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        RD_I,
        GET_I,
        RD_J,
        GET_J,
        WR_I,
        WR_J,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  i_q, i_d;
    logic [7:0]  j_q, j_d;
    logic [7:0]  si_q, si_d;
    logic [7:0]  sj_q, sj_d;
    logic [1:0]  kidx_q, kidx_d;   // i mod 3, wraps 2 -> 0

    // State RAM: single port, synchronous read with 1-cycle latency.
    logic [7:0]  mem [0:255];
    logic [7:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  q_q, q_d;
    logic [7:0]  key_byte;

    assign busy = (state_q != IDLE) && (state_q != DONE);
    assign done = (state_q == DONE);

`ifdef KSA_DEBUG_PORT_EN
    assign dbg_q = q_q;
`endif

    always_comb begin
        case (kidx_q)
            2'd0:    key_byte = secret_key[23:16];
            2'd1:    key_byte = secret_key[15:8];
            default: key_byte = secret_key[7:0];
        endcase
    end

    assign q_d = mem[ram_addr];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        sj_d      = sj_q;
        kidx_d    = kidx_q;
        ram_we    = 1'b0;
        ram_addr  = i_q;
        ram_wdata = i_q;

        case (state_q)
            IDLE: begin
                i_d = 8'd0;
                j_d = 8'd0;
                if (start) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                ram_we    = 1'b1;
                ram_addr  = i_q;
                ram_wdata = i_q;
                i_d       = i_q + 8'd1;
                if (i_q == 8'd255) begin
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    kidx_d  = 2'd0;
                    state_d = RD_I;
                end
            end
            RD_I: begin
                ram_addr = i_q;
                state_d  = GET_I;
            end
            GET_I: begin
                si_d    = q_q;
                j_d     = j_q + q_q + key_byte;   // 8-bit wrap
                state_d = RD_J;
            end
            RD_J: begin
                ram_addr = j_q;
                state_d  = GET_J;
            end
            GET_J: begin
                sj_d    = q_q;
                state_d = WR_I;
            end
            WR_I: begin
                ram_we    = 1'b1;
                ram_addr  = i_q;
                ram_wdata = sj_q;
                state_d   = WR_J;
            end
            WR_J: begin
                // When i == j both writes hit one location with si == sj,
                // so the final value is unchanged.
                ram_we    = 1'b1;
                ram_addr  = j_q;
                ram_wdata = si_q;
                kidx_d    = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
                if (i_q == 8'd255) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    state_d = RD_I;
                end
            end
            DONE: begin
                // A start coinciding with the done pulse begins a fresh run.
                i_d     = 8'd0;
                j_d     = 8'd0;
                state_d = start ? INIT : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef KSA_DEBUG_PORT_EN
        if (!busy && dbg_rd) begin
            ram_addr = dbg_addr;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            kidx_q  <= 2'd0;
            q_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            kidx_q  <= kidx_d;
            q_q     <= q_d;
        end
    end

endmodule

// File: tb/tb_ksa_core.sv
// Bench for ksa_core: randomized keys plus directed cases; a scoreboard queue
// holds the expected done cycle and key of each accepted run, and a monitor
// checks every done pulse against a plain-arithmetic RC4 KSA model.

module tb_ksa_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [23:0] secret_key = 24'd0;
    logic        busy;
    logic        done;
`ifdef KSA_DEBUG_PORT_EN
    logic        dbg_rd = 1'b0;
    logic [7:0]  dbg_addr = 8'd0;
    logic [7:0]  dbg_q;
`endif

    ksa_core dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .secret_key (secret_key),
        .busy       (busy),
        .done       (done)
`ifdef KSA_DEBUG_PORT_EN
        ,
        .dbg_rd     (dbg_rd),
        .dbg_addr   (dbg_addr),
        .dbg_q      (dbg_q)
`endif
    );

    always #5 clk = ~clk;

    // cyc labels the clock period: the period following edge E is E+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int unsigned due;
        logic [23:0] key;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [7:0] ms [256];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference RC4 KSA, first 'iters' swap iterations.
    task automatic model_ksa(input logic [23:0] key, input int iters);
        int   j;
        int   kb [3];
        logic [7:0] t;
        kb[0] = int'(key[23:16]);
        kb[1] = int'(key[15:8]);
        kb[2] = int'(key[7:0]);
        for (int i = 0; i < 256; i++) ms[i] = 8'(i);
        j = 0;
        for (int i = 0; i < iters; i++) begin
            j = (j + int'(ms[i]) + kb[i % 3]) % 256;
            t = ms[i]; ms[i] = ms[j]; ms[j] = t;
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding run.
    always @(negedge clk) begin : mon
        exp_t e;
        int   mism, dups, sum;
        int   seen [256];
        if (rst && done) begin
            check("done_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("done_cycle", cyc, int'(e.due));
                check("busy_low_at_done", int'(busy), 0);
                model_ksa(e.key, 256);
                mism = 0; dups = 0; sum = 0;
                for (int a = 0; a < 256; a++) seen[a] = 0;
                for (int a = 0; a < 256; a++) begin
                    if (dut.mem[a] !== ms[a]) mism++;
                    seen[dut.mem[a]]++;
                    sum += int'(dut.mem[a]);
                end
                for (int a = 0; a < 256; a++) if (seen[a] != 1) dups++;
                check("ram_vs_model", mism, 0);
                check("perm_unique", dups, 0);
                check("perm_sum", sum, 32640);
            end
        end
    end

    // Call at a negedge with the DUT idle (or in its done cycle).
    task automatic do_start(input logic [23:0] key, output int e);
        exp_t x;
        secret_key = key;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = cyc - 1;
        x.due = 32'(e + 1793);
        x.key = key;
        sb.push_back(x);
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", int'(sb.size()), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : drv
        int e, e2, mism;
        logic [23:0] k;

        // Reset state.
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
`ifdef KSA_DEBUG_PORT_EN
        check("reset_dbg_q", int'(dbg_q), 0);
`endif
        rst = 1'b1;
        @(negedge clk);

        // Key 000249: init contents, done timing, full result (monitor).
        do_start(24'h000249, e);
        wait_to(e + 257);
        mism = 0;
        for (int a = 0; a < 256; a++) if (dut.mem[a] !== 8'(a)) mism++;
        check("init_identity", mism, 0);
        check("init_s0", int'(dut.mem[0]), 0);
        check("init_s255", int'(dut.mem[255]), 255);
        wait_to(e + 1792);
        check("done_not_early", int'(done), 0);
        wait_drain(2000);

`ifdef KSA_DEBUG_PORT_EN
        model_ksa(24'h000249, 256);
        for (int n = 0; n < 6; n++) begin
            k = 24'($urandom);
            dbg_rd = 1'b1;
            dbg_addr = k[7:0];
            @(posedge clk);
            @(negedge clk);
            check("dbg_read", int'(dbg_q), int'(ms[k[7:0]]));
        end
        dbg_rd = 1'b0;
`endif

        // Key 0: early swap loop state, then restart in the done cycle.
        do_start(24'h000000, e);
        wait_to(e + 275);
        check("key0_s2", int'(dut.mem[2]), 3);
        check("key0_s3", int'(dut.mem[3]), 2);
        model_ksa(24'h000000, 3);
        mism = 0;
        for (int a = 0; a < 256; a++) if (dut.mem[a] !== ms[a]) mism++;
        check("key0_partial_model", mism, 0);
        wait_to(e + 1793);
        do_start(24'($urandom), e2);

        // Re-pulse start mid-run: must be ignored.
        wait_to(e2 + 100);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain(4000);
        @(negedge clk);
        check("idle_after_done", int'(busy), 0);

        // Reset mid-KSA aborts at once; a new run then completes normally.
        do_start(24'($urandom), e);
        wait_to(e + 800);
        rst = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_start(24'($urandom), e);
        wait_drain(2000);

        // Random keys.
        for (int n = 0; n < 4; n++) begin
            do_start(24'($urandom), e);
            wait_drain(2000);
        end

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
